// File: rtl/proc_pkg.sv
// Shared types for proc_core: opcodes, FSM states, PSR bit positions and
// branch condition codes.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_STR = 4'd2,
        OP_BRA = 4'd3,
        OP_XOR = 4'd4,
        OP_ADD = 4'd5,
        OP_ROT = 4'd6,
        OP_SHF = 4'd7,
        OP_HLT = 4'd8,
        OP_CMP = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    localparam int PSR_C = 0;
    localparam int PSR_P = 1;
    localparam int PSR_E = 2;
    localparam int PSR_N = 3;
    localparam int PSR_Z = 4;

    localparam logic [2:0] CC_ALWAYS = 3'd0;

endpackage

// File: rtl/proc_alu.sv
// Combinational datapath for LD/XOR/ADD/ROT/SHF/CMP plus PSR flag generation.
// i_a is the destination register value, i_b the source operand S.
module proc_alu
    import proc_pkg::*;
#(
    parameter int BUSW = 12
) (
    input  op_e             i_op,
    input  logic [BUSW-1:0] i_a,
    input  logic [BUSW-1:0] i_b,
    input  logic [BUSW-1:0] i_cnt,
    output logic [BUSW-1:0] o_res,
    output logic [4:0]      o_flags
);

    localparam logic [BUSW-1:0] WIDTH_V = BUSW'(BUSW);

    logic [BUSW:0]   w_sum;
    logic            w_cnt_neg;
    logic [BUSW-1:0] w_cnt_mag;
    logic [BUSW-1:0] w_rot_amt;
    logic [BUSW-1:0] w_rot_l;
    logic [BUSW-1:0] w_rot_r;
    logic [BUSW-1:0] w_shf;

    assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
    // The count is two's-complement; its magnitude always fits unsigned in BUSW bits.
    assign w_cnt_neg = i_cnt[BUSW-1];
    assign w_cnt_mag = w_cnt_neg ? (~i_cnt + BUSW'(1)) : i_cnt;
    assign w_rot_amt = w_cnt_mag % WIDTH_V;
    assign w_rot_l   = (i_a << w_rot_amt) | (i_a >> (WIDTH_V - w_rot_amt));
    assign w_rot_r   = (i_a >> w_rot_amt) | (i_a << (WIDTH_V - w_rot_amt));
    assign w_shf     = (w_cnt_mag >= WIDTH_V) ? '0 :
                       (w_cnt_neg ? (i_a >> w_cnt_mag) : (i_a << w_cnt_mag));

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_LD:   o_res = i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_ADD:  o_res = w_sum[BUSW-1:0];
            OP_ROT:  o_res = w_cnt_neg ? w_rot_r : w_rot_l;
            OP_SHF:  o_res = w_shf;
            OP_CMP:  o_res = ~i_b;
            default: o_res = '0;
        endcase
    end

    always_comb begin
        o_flags        = '0;
        o_flags[PSR_C] = (i_op == OP_ADD) && w_sum[BUSW];
        o_flags[PSR_P] = ^o_res;
        o_flags[PSR_E] = ~o_res[0];
        o_flags[PSR_N] = o_res[BUSW-1];
        o_flags[PSR_Z] = ~|o_res;
    end

endmodule

// File: rtl/proc_core.sv
// Multi-cycle decoded-instruction core: IDLE -> READ -> EXEC -> WB.
// Define PROC_ILLEGAL_TRAP_EN to trap opcodes 10-15 into HALT with illegal=1.
module proc_core
    import proc_pkg::*;
#(
    parameter int BUSW   = 12,
    parameter int RWORDS = 8,
    parameter int MWORDS = 8,
    parameter int PCW    = 8,
    parameter int PSRW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      opcode,
    input  logic            src_is_imm,
    input  logic [BUSW-1:0] src_op,
    input  logic [BUSW-1:0] dst_op,
    output logic [BUSW-1:0] res,
    output logic            res_valid,
    output logic [PSRW-1:0] status,
    output logic [PCW-1:0]  pc,
    output logic            halted,
    output logic            illegal
);

    localparam int RIW = (RWORDS > 1) ? $clog2(RWORDS) : 1;
    localparam int MIW = (MWORDS > 1) ? $clog2(MWORDS) : 1;

    state_e          r_state;
    op_e             r_op;
    logic            r_imm;
    logic [BUSW-1:0] r_src;
    logic [BUSW-1:0] r_dst;
    logic [BUSW-1:0] r_a;
    logic [BUSW-1:0] r_b;
    logic [BUSW-1:0] r_result;
    logic [PSRW-1:0] r_flags;
    logic            r_upd_psr;
    logic            r_reg_we;
    logic            r_mem_we;
    logic            r_taken;
    logic [BUSW-1:0] r_res;
    logic            r_res_valid;
    logic [PSRW-1:0] r_status;
    logic [PCW-1:0]  r_pc;
    logic            r_halted;
    logic [BUSW-1:0] r_regs [RWORDS];
    logic [BUSW-1:0] r_mem  [MWORDS];

    logic [BUSW-1:0] w_alu_res;
    logic [4:0]      w_alu_flags;
    logic [2:0]      w_cc;
    logic [7:0]      w_cc_flags;
    logic            w_taken;
    logic [PCW-1:0]  w_bra_pc;
    logic            w_unused;

    proc_alu #(.BUSW(BUSW)) u_alu (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_cnt   (r_src),
        .o_res   (w_alu_res),
        .o_flags (w_alu_flags)
    );

    // cc=0 always; cc=1..5 test PSR[cc-1]; zero padding makes 6 and 7 never taken.
    assign w_cc       = r_src[2:0];
    assign w_cc_flags = {3'b000, r_status};
    assign w_taken    = (w_cc == CC_ALWAYS) || w_cc_flags[w_cc - 3'd1];
    assign w_bra_pc   = w_taken ? r_dst[PCW-1:0] : r_pc + PCW'(1);
    assign w_unused   = &{1'b0, r_dst};

    assign instr_ready = (r_state == ST_IDLE);
    assign res         = r_res;
    assign res_valid   = r_res_valid;
    assign status      = r_status;
    assign pc          = r_pc;
    assign halted      = r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_imm       <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_upd_psr   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_taken     <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_status    <= '0;
            r_pc        <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= op_e'(opcode);
                        r_imm   <= src_is_imm;
                        r_src   <= src_op;
                        r_dst   <= dst_op;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_a <= r_regs[r_dst[RIW-1:0]];
                    if (r_imm)
                        r_b <= r_src;
                    else if (r_op == OP_LD)
                        r_b <= r_mem[r_src[MIW-1:0]];
                    else
                        r_b <= r_regs[r_src[RIW-1:0]];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_upd_psr <= 1'b0;
                    r_reg_we  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_taken   <= 1'b0;
                    r_result  <= '0;
                    r_flags   <= w_alu_flags;
                    r_state   <= ST_WB;
                    case (r_op)
                        OP_LD, OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: begin
                            r_result  <= w_alu_res;
                            r_upd_psr <= 1'b1;
                            r_reg_we  <= 1'b1;
                        end
                        OP_STR: begin
                            r_result <= r_b;
                            r_mem_we <= 1'b1;
                        end
                        OP_BRA: begin
                            r_result <= BUSW'(w_bra_pc);
                            r_taken  <= w_taken;
                        end
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        default: begin
`ifdef PROC_ILLEGAL_TRAP_EN
                            if (r_op >= 4'd10) begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
`endif
                        end
                    endcase
                end
                ST_WB: begin
                    r_res       <= r_result;
                    r_res_valid <= 1'b1;
                    if (r_upd_psr)
                        r_status <= r_flags;
                    r_pc    <= r_taken ? r_dst[PCW-1:0] : r_pc + PCW'(1);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RWORDS; i++) r_regs[i] <= '0;
            for (int i = 0; i < MWORDS; i++) r_mem[i]  <= '0;
        end else if (r_state == ST_WB) begin
            if (r_reg_we) r_regs[r_dst[RIW-1:0]] <= r_result;
            if (r_mem_we) r_mem[r_dst[MIW-1:0]]  <= r_result;
        end
    end

`ifdef PROC_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk) begin
        if (rst)
            r_illegal <= 1'b0;
        else if (r_state == ST_EXEC && r_op >= 4'd10)
            r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/proc_core.md
Name: proc_core

Overview:
- Parametrised multi-cycle successor to the 10-instruction processor top.
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Executes it against an internal register bank and data memory, then returns the written result, the PSR and a program counter.
- Sits between the instruction sequencer and the testbench/debug path.

Parameters:
BUSW, 12, data/operand width in bits (>=4)
RWORDS, 8, register bank depth
MWORDS, 8, data memory depth
PCW, 8, program counter width
PSRW, 5, status width (fixed layout; must be 5)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  core can accept (IDLE only)
opcode  in  4  NOP=0 LD=1 STR=2 BRA=3 XOR=4 ADD=5 ROT=6 SHF=7 HLT=8 CMP=9
src_is_imm  in  1  source operand is immediate (else register/memory index)
src_op  in  BUSW  source index, immediate, signed shift/rotate count, or BRA condition code (bits 2:0)
dst_op  in  BUSW  destination index or branch target
res  out  BUSW  value written by the completed instruction
res_valid  out  1  one-cycle pulse on completion
status  out  PSRW  PSR: [0]carry [1]parity(odd) [2]even [3]negative [4]zero
pc  out  PCW  program counter
halted  out  1  core stopped by HLT/trap
illegal  out  1  illegal opcode trapped (tied 0 without macro)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset: state=IDLE; res, status, pc, all registers and memory words cleared to 0; res_valid, halted and illegal low.
- Reset mid-instruction aborts it: no writeback, no res_valid.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE; HALT is terminal until rst.
- IDLE: instr_ready=1. On instr_valid, latch the instruction and go to READ.
- READ: latch operands. Register index uses the low $clog2(RWORDS) bits; memory index uses the low $clog2(MWORDS) bits.
- EXEC: compute the result and PSR.
- WB: write the destination; res_valid=1 for exactly one cycle; update pc.
- Latency: res_valid occurs 3 cycles after the acceptance edge. Throughput is one instruction per 4 cycles.
- Instruction semantics (S = src_is_imm ? src_op : reg[src]):
  - LD: reg[dst] <= src_is_imm ? src_op : mem[src].
  - STR: mem[dst] <= S.
  - XOR: reg[dst] <= reg[dst] ^ S.
  - ADD: reg[dst] <= reg[dst] + S, modulo 2^BUSW; carry = carry-out.
  - ROT/SHF: count is always src_op, interpreted as signed two's-complement. Positive = left, negative = right.
    - SHF: logical shift, zero fill; |count| >= BUSW yields 0.
    - ROT: rotate by |count| mod BUSW.
  - CMP: reg[dst] <= ~S.
  - BRA: taken if cc=0 (always), or the PSR bit at cc-1 is set (cc=1..5). cc=6,7 is never taken.
  - NOP: res=0.
  - HLT: goes to HALT with halted=1 and no res_valid; instr_ready stays 0.
- res value: STR gives the stored value; BRA gives the new pc zero-extended.
- PSR update:
  - LD, XOR, ADD, ROT, SHF and CMP update parity (XOR-reduce of result), even (~result[0]), negative (result[BUSW-1]) and zero.
  - Carry is set only by ADD and cleared by the other result-writing ops.
  - STR, BRA and NOP leave the PSR unchanged.
- pc: a taken BRA loads dst_op[PCW-1:0]; every other completed instruction increments pc, wrapping at 2^PCW.
- instr_valid outside IDLE is ignored and the inputs are not sampled.
- Opcodes 10-15 without the macro: treated as NOP.

Optional Feature:
PROC_ILLEGAL_TRAP_EN
- Defined: opcodes 10-15 set illegal=1 and halted=1 and go to HALT in EXEC; pc holds; no res_valid.
- Undefined: opcodes 10-15 execute as NOP; illegal is tied 0.

Decomposition:
- proc_pkg holds:
  - opcode enum
  - FSM state enum
  - PSR bit index constants
  - BRA condition-code constants
- Sub-module proc_alu: combinational XOR/ADD/ROT/SHF/CMP datapath plus PSR flag generation, parametrised by BUSW.

Test Plan:
1. rst, then LD r1 imm 0x0FF -> res_valid 3 cycles after acceptance; res=0x0FF; status=00000; pc=1.
2. ADD r1 imm 0xF01 (r1=0x0FF) -> res=0x000; status carry=1, zero=1, even=1, parity=0 (status=10101).
3. With r1=0xABC: STR mem[3] from r1 then LD r2 from mem[3] -> STR res=0xABC, LD res=0xABC; PSR after STR unchanged.
4. With r2=0x801: SHF r2 by +1 -> 0x002. Reload r2=0x801: SHF by -1 (src 0xFFF) -> 0x400. Reload r2=0x801: ROT by +1 -> 0x003. Reload r2=0x801: SHF by 12 -> 0x000.
5. After test 2: BRA cc=5 (zero) dst 0x20 -> pc=0x20, res=0x020. Then BRA cc=7 -> not taken, pc=0x21.
6. HLT -> halted=1, instr_ready=0 for 10+ cycles with instr_valid=1; rst -> IDLE, pc=0. Opcode 0xA -> with macro illegal=1 and halted=1; without macro res=0, pc increments.
